// File: rtl/core_pkg.sv
// Shared definitions for the accumulator core: opcodes, fetch FSM states,
// the halt encoding and the absolute branch-target table.
package core_pkg;

   typedef enum logic [2:0] {
      LDR   = 3'd0,
      STR   = 3'd1,
      MOV   = 3'd2,
      XOR   = 3'd3,
      AND   = 3'd4,
      SHIFT = 3'd5,
      CMP   = 3'd6,
      BR    = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   // BR with this operand is the halt marker, never a real branch.
   localparam logic [5:0] HALT_OPERAND = 6'h3F;

   localparam int unsigned LUT_DEPTH = 32;
   localparam int unsigned LUT_W     = 16;

   // Absolute branch targets, indexed by operand[4:0].
   localparam logic [LUT_W-1:0] BRANCH_TARGETS [LUT_DEPTH] = '{
      16'd0,   16'd20,  16'd40,  16'd60,  16'd80,  16'd100, 16'd120, 16'd140,
      16'd160, 16'd180, 16'd200, 16'd220, 16'd240, 16'd260, 16'd280, 16'd300,
      16'd320, 16'd340, 16'd360, 16'd380, 16'd400, 16'd420, 16'd440, 16'd460,
      16'd480, 16'd500, 16'd520, 16'd540, 16'd560, 16'd580, 16'd600, 16'd620
   };

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: harness handshake, ROM read and decoder feedback.
interface fetch_unit_if #(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 9,
   parameter int CNT_W   = 16
);
   logic               start;
   logic [INSTR_W-1:0] instr_in;
   logic               branch;
   logic [PC_W-1:0]    pc;
   logic [2:0]         opcode;
   logic [5:0]         operand;
   logic               valid;
   logic               done;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      output start, instr_in, branch,
      input  pc, opcode, operand, valid, done, instr_count
   );

   modport slave (
      input  start, instr_in, branch,
      output pc, opcode, operand, valid, done, instr_count
   );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup from the shared constant table.
module branch_lut
   import core_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic [4:0]      idx_i,
   output logic [PC_W-1:0] target_o
);

   // Table entries are stored wide and truncated to the PC width in use.
   always_comb begin
      target_o = PC_W'(BRANCH_TARGETS[idx_i]);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: PC register, next-PC select, run FSM and
// executed-instruction counter.
module fetch_unit
   import core_pkg::*;
#(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 9,
   parameter int CNT_W   = 16
) (
   input logic         clk,
   input logic         reset,
   fetch_unit_if.slave bus
);

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  br_target;
   logic [2:0]       opcode;
   logic [5:0]       operand;
   logic             halt;

   assign opcode  = bus.instr_in[INSTR_W-1 -: 3];
   assign operand = bus.instr_in[5:0];
   assign halt    = (opcode == BR) && (operand == HALT_OPERAND);

   branch_lut #(.PC_W(PC_W)) u_lut (
      .idx_i    (operand[4:0]),
      .target_o (br_target)
   );

   // State, PC and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, next PC (halt > branch > increment) and saturating count.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_DONE;
            end else begin
               pc_d = bus.branch ? br_target : pc_q + 1'b1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output drive: decode fields pass through, status follows the state.
   always_comb begin
      bus.pc          = pc_q;
      bus.opcode      = opcode;
      bus.operand     = operand;
      bus.valid       = (state_q == ST_RUN) && !halt;
      bus.done        = (state_q == ST_DONE);
      bus.instr_count = cnt_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed programs plus random programs checked
// against an execution trace computed from the program contents.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(10), .INSTR_W(9), .CNT_W(16)) ifa ();
   fetch_unit_if #(.PC_W(4),  .INSTR_W(9), .CNT_W(16)) ifb ();

   fetch_unit #(.PC_W(10), .INSTR_W(9), .CNT_W(16)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ifa)
   );

   fetch_unit #(.PC_W(4), .INSTR_W(9), .CNT_W(16)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifb)
   );

   // Program ROM and per-address decoder Branch response for DUT A.
   logic [8:0] rom_a [1024];
   bit         br_a  [1024];

   always_comb ifa.instr_in = rom_a[ifa.pc];
   always_comb ifa.branch   = br_a[ifa.pc];

   // DUT B executes straight-line MOVs with no branches.
   always_comb ifb.instr_in = {3'd2, 6'd0};
   always_comb ifb.branch   = 1'b0;

   int unsigned exp_pc [$];
   int          halt_at;

   function automatic int unsigned lut_target(input logic [4:0] idx);
      return int'(idx) * 20;
   endfunction

   function automatic logic [8:0] mov_word();
      logic [5:0] op;
      op = 6'($urandom_range(63));
      return {3'd2, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Walk the program as an interpreter would, recording the PC per cycle.
   task automatic build_trace(input int budget);
      int unsigned p;
      logic [8:0]  w;
      exp_pc.delete();
      halt_at = -1;
      p = 0;
      for (int c = 0; c < budget; c++) begin
         exp_pc.push_back(p);
         w = rom_a[p];
         if (w == 9'h1FF) begin
            halt_at = c;
            break;
         end
         if (br_a[p]) p = lut_target(w[4:0]);
         else         p = (p + 1) % 1024;
      end
   endtask

   task automatic run_program(input string name, input int budget, input bit hold_start);
      build_trace(budget);
      ifa.start = 1'b1;
      tick();
      if (!hold_start) ifa.start = 1'b0;
      for (int c = 0; c < exp_pc.size(); c++) begin
         check({name, ":pc"},    32'(ifa.pc), exp_pc[c]);
         check({name, ":valid"}, 32'(ifa.valid), 32'(c != halt_at));
         check({name, ":done"},  32'(ifa.done), 32'd0);
         check({name, ":count"}, 32'(ifa.instr_count), 32'(c));
         if (c == halt_at) ifa.start = 1'b0;
         tick();
      end
      ifa.start = 1'b0;
      if (halt_at >= 0) begin
         for (int k = 0; k < 2; k++) begin
            check({name, ":done_hi"},  32'(ifa.done), 32'd1);
            check({name, ":pc_hold"},  32'(ifa.pc), exp_pc[halt_at]);
            check({name, ":cnt_hold"}, 32'(ifa.instr_count), 32'(halt_at));
            check({name, ":valid_lo"}, 32'(ifa.valid), 32'd0);
            tick();
         end
      end
   endtask

   task automatic fill_mov();
      for (int i = 0; i < 1024; i++) begin
         rom_a[i] = mov_word();
         br_a[i]  = 1'b0;
      end
   endtask

   initial begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      fill_mov();

      // Reset, then idle cycles.
      tick();
      tick();
      rst_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("idle:pc",    32'(ifa.pc), 32'd0);
         check("idle:valid", 32'(ifa.valid), 32'd0);
         check("idle:done",  32'(ifa.done), 32'd0);
         check("idle:count", 32'(ifa.instr_count), 32'd0);
         tick();
      end

      // Five MOVs then halt; Branch forced high on the halt word.
      rom_a[5] = 9'h1FF;
      br_a[5]  = 1'b1;
      run_program("seq5", 50, 1'b0);
      check("seq5:final_count", 32'(ifa.instr_count), 32'd5);
      check("seq5:final_pc",    32'(ifa.pc), 32'd5);

      // Taken branch at address 3 to LUT[2]=40, restarted from DONE.
      fill_mov();
      rom_a[3]  = {3'd7, 6'd2};
      br_a[3]   = 1'b1;
      rom_a[40] = 9'h1FF;
      run_program("br_taken", 50, 1'b0);
      check("br_taken:pc", 32'(ifa.pc), 32'd40);

      // Same branch not taken; start held through the whole run.
      br_a[3]  = 1'b0;
      rom_a[4] = 9'h1FF;
      run_program("br_fall", 50, 1'b1);
      check("br_fall:pc", 32'(ifa.pc), 32'd4);

      // Random programs without halt, reset mid-run.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 1024; i++) begin
            rom_a[i] = 9'($urandom_range(511));
            if (rom_a[i] == 9'h1FF) rom_a[i] = 9'h1FE;
            br_a[i] = ($urandom_range(3) == 0);
         end
         run_program("rand", 40, 1'b0);
         rst_a = 1'b1;
         tick();
         rst_a = 1'b0;
         check("rand_rst:pc",    32'(ifa.pc), 32'd0);
         check("rand_rst:valid", 32'(ifa.valid), 32'd0);
         check("rand_rst:done",  32'(ifa.done), 32'd0);
         check("rand_rst:count", 32'(ifa.instr_count), 32'd0);
         tick();
         check("rand_idle:count", 32'(ifa.instr_count), 32'd0);
         check("rand_idle:pc",    32'(ifa.pc), 32'd0);
      end

      // Narrow PC wraps 15 -> 0 and keeps counting; reset at count 20.
      rst_b = 1'b0;
      tick();
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         check("wrap:pc",    32'(ifb.pc), 32'(c % 16));
         check("wrap:count", 32'(ifb.instr_count), 32'(c));
         check("wrap:valid", 32'(ifb.valid), 32'd1);
         if (c == 20) rst_b = 1'b1;
         tick();
      end
      rst_b = 1'b0;
      check("wrap_rst:pc",    32'(ifb.pc), 32'd0);
      check("wrap_rst:valid", 32'(ifb.valid), 32'd0);
      check("wrap_rst:count", 32'(ifb.instr_count), 32'd0);
      tick();
      check("wrap_idle:count", 32'(ifb.instr_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
